// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer controller address generators.
// Provides default widths, layer/step encodings and the address-generator state type.
// No ports; imported by nested_index_counter and linear_mac_addr_gen.
package nn_pkg;

    // Default widths for address ports/registers and size inputs/index counters.
    localparam int ADDR_BITS_DEF = 32;
    localparam int SIZE_BITS_DEF = 10;

    // Layer-type encodings used by the layer controller.
    localparam logic [2:0] DENSE  = 3'd0;
    localparam logic [2:0] RELU   = 3'd2;
    localparam logic [2:0] MOVE   = 3'd5;
    localparam logic [2:0] OUTPUT = 3'd6;

    // Steps within a DENSE (linear) layer.
    localparam logic [0:0] INIT_BIAS  = 1'b0;
    localparam logic [0:0] MAC_OUTPUT = 1'b1;

    // Handshake state shared by the address generators.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        VALID = 2'd2,
        DONE  = 2'd3
    } addr_gen_state_t;

endpackage : nn_pkg

// File: rtl/nested_index_counter.sv
// Two nested index counters (outer x inner) with three running-sum addresses.
// Ports: load_in latches bases/sizes and clears indices; advance_in steps one tuple.
//   inner_addr = inner_base + inner_idx; stride_addr = stride_base + linear tuple count;
//   outer_addr = outer_base + outer_idx; inner/outer_last flags; registered row_last_out.
module nested_index_counter
    import nn_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int SIZE_BITS = SIZE_BITS_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 load_in,
    input  logic                 advance_in,
    input  logic [ADDR_BITS-1:0] inner_base_in,
    input  logic [ADDR_BITS-1:0] stride_base_in,
    input  logic [ADDR_BITS-1:0] outer_base_in,
    input  logic [SIZE_BITS-1:0] outer_size_in,
    input  logic [SIZE_BITS-1:0] inner_size_in,
    output logic                 inner_last_out,
    output logic                 outer_last_out,
    output logic [ADDR_BITS-1:0] inner_addr_out,
    output logic [ADDR_BITS-1:0] stride_addr_out,
    output logic [ADDR_BITS-1:0] outer_addr_out,
    output logic                 row_last_out
);

    localparam logic [SIZE_BITS-1:0] ONE_S = SIZE_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ONE_A = ADDR_BITS'(1);

    logic [SIZE_BITS-1:0] outer_idx_q,       outer_idx_d;
    logic [SIZE_BITS-1:0] inner_idx_q,       inner_idx_d;
    // Sizes are stored as (size-1) so the last-index compares need no subtractor.
    logic [SIZE_BITS-1:0] outer_last_idx_q,  outer_last_idx_d;
    logic [SIZE_BITS-1:0] inner_last_idx_q,  inner_last_idx_d;
    logic [ADDR_BITS-1:0] inner_base_q,      inner_base_d;
    logic [ADDR_BITS-1:0] inner_addr_q,      inner_addr_d;
    logic [ADDR_BITS-1:0] stride_addr_q,     stride_addr_d;
    logic [ADDR_BITS-1:0] outer_addr_q,      outer_addr_d;
    logic                 row_last_q,        row_last_d;

    logic inner_last;
    logic outer_last;

    assign inner_last = (inner_idx_q == inner_last_idx_q);
    assign outer_last = (outer_idx_q == outer_last_idx_q);

    always_comb begin
        outer_idx_d      = outer_idx_q;
        inner_idx_d      = inner_idx_q;
        outer_last_idx_d = outer_last_idx_q;
        inner_last_idx_d = inner_last_idx_q;
        inner_base_d     = inner_base_q;
        inner_addr_d     = inner_addr_q;
        stride_addr_d    = stride_addr_q;
        outer_addr_d     = outer_addr_q;
        row_last_d       = row_last_q;

        if (load_in) begin
            outer_idx_d      = '0;
            inner_idx_d      = '0;
            outer_last_idx_d = outer_size_in - ONE_S;
            inner_last_idx_d = inner_size_in - ONE_S;
            inner_base_d     = inner_base_in;
            inner_addr_d     = inner_base_in;
            stride_addr_d    = stride_base_in;
            outer_addr_d     = outer_base_in;
            // A one-element row makes the very first tuple a row end.
            row_last_d       = (inner_size_in == ONE_S);
        end else if (advance_in) begin
            // The stride address walks a row-major matrix, so it bumps on every tuple.
            stride_addr_d = stride_addr_q + ONE_A;
            if (inner_last) begin
                inner_idx_d  = '0;
                outer_idx_d  = outer_idx_q + ONE_S;
                inner_addr_d = inner_base_q;
                outer_addr_d = outer_addr_q + ONE_A;
                row_last_d   = (inner_last_idx_q == '0);
            end else begin
                inner_idx_d  = inner_idx_q + ONE_S;
                inner_addr_d = inner_addr_q + ONE_A;
                row_last_d   = ((inner_idx_q + ONE_S) == inner_last_idx_q);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            outer_idx_q      <= '0;
            inner_idx_q      <= '0;
            outer_last_idx_q <= '0;
            inner_last_idx_q <= '0;
            inner_base_q     <= '0;
            inner_addr_q     <= '0;
            stride_addr_q    <= '0;
            outer_addr_q     <= '0;
            row_last_q       <= 1'b0;
        end else begin
            outer_idx_q      <= outer_idx_d;
            inner_idx_q      <= inner_idx_d;
            outer_last_idx_q <= outer_last_idx_d;
            inner_last_idx_q <= inner_last_idx_d;
            inner_base_q     <= inner_base_d;
            inner_addr_q     <= inner_addr_d;
            stride_addr_q    <= stride_addr_d;
            outer_addr_q     <= outer_addr_d;
            row_last_q       <= row_last_d;
        end
    end

    assign inner_last_out  = inner_last;
    assign outer_last_out  = outer_last;
    assign inner_addr_out  = inner_addr_q;
    assign stride_addr_out = stride_addr_q;
    assign outer_addr_out  = outer_addr_q;
    assign row_last_out    = row_last_q;

endmodule : nested_index_counter

// File: rtl/linear_mac_addr_gen.sv
// DENSE-layer MAC_OUTPUT address generator: one (input, weight, output) tuple per handshake.
// Latency: first ready_out 2 cycles after start; one tuple per 2 cycles at most (bubble state).
// Backpressure: tuple held stable while ready_out=1 and next_ready_in=0; start aborts any walk.
module linear_mac_addr_gen
    import nn_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int SIZE_BITS = SIZE_BITS_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_ready_in,
    input  logic                 next_ready_in,
    input  logic [ADDR_BITS-1:0] input_base_addr_in,
    input  logic [ADDR_BITS-1:0] weight_base_addr_in,
    input  logic [ADDR_BITS-1:0] output_base_addr_in,
    input  logic [SIZE_BITS-1:0] m_size_in,
    input  logic [SIZE_BITS-1:0] chw_size_in,
    output logic [ADDR_BITS-1:0] input_addr_out,
    output logic [ADDR_BITS-1:0] weight_addr_out,
    output logic [ADDR_BITS-1:0] output_addr_out,
    output logic                 row_last_out,
    output logic                 ready_out,
    output logic                 done_out
);

    addr_gen_state_t state_q, state_d;

    logic load;
    logic advance;
    logic k_last;
    logic m_last;
    logic empty_cfg;

    assign empty_cfg = (m_size_in == '0) || (chw_size_in == '0);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;

        // Start outranks everything, including an accept in the same cycle.
        if (start_ready_in) begin
            load    = 1'b1;
            state_d = empty_cfg ? DONE : STEP;
        end else begin
            unique case (state_q)
                IDLE:  state_d = IDLE;
                // The bubble absorbs a lingering registered next_ready_in from the consumer.
                STEP:  state_d = VALID;
                VALID: begin
                    if (next_ready_in) begin
                        if (m_last && k_last) begin
                            // Addresses intentionally keep the final tuple.
                            state_d = DONE;
                        end else begin
                            advance = 1'b1;
                            state_d = STEP;
                        end
                    end
                end
                DONE:  state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Inner loop walks input elements (k), outer loop walks output rows (m).
    nested_index_counter #(
        .ADDR_BITS (ADDR_BITS),
        .SIZE_BITS (SIZE_BITS)
    ) u_counter (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .load_in         (load),
        .advance_in      (advance),
        .inner_base_in   (input_base_addr_in),
        .stride_base_in  (weight_base_addr_in),
        .outer_base_in   (output_base_addr_in),
        .outer_size_in   (m_size_in),
        .inner_size_in   (chw_size_in),
        .inner_last_out  (k_last),
        .outer_last_out  (m_last),
        .inner_addr_out  (input_addr_out),
        .stride_addr_out (weight_addr_out),
        .outer_addr_out  (output_addr_out),
        .row_last_out    (row_last_out)
    );

    assign ready_out = (state_q == VALID);
    assign done_out  = (state_q == DONE);

endmodule : linear_mac_addr_gen
